// File: rtl/spi_reg_bridge.sv
// ---------------------------------------------------------------------------
// spi_reg_bridge
//
// Purpose:
//   Byte-level command decoder placed after the SPI byte transceiver. It turns
//   SPI frames into single-byte register reads and writes on an 8-bit register
//   bus. A frame is one command byte followed by any number of data bytes.
//   Command bit 7 selects write (1) or read (0). The low ADDR_W bits give the
//   start address, and the address auto-increments for each data byte. Read
//   data goes back to the transceiver on tx_data/tx_ack, so it is shifted out
//   on MISO during the next byte slot.
//
// Parameters:
//   ADDR_W      register address width (1..7)
//   IDLE_BYTE   byte presented on MISO during the command byte and write frames
//   RD_TIMEOUT  cycles to wait for reg_rvalid after reg_re (1..255)
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   ss                 raw SPI slave select (active-low), synchronised here
//   rx_data, rx_ack    received byte and its one-cycle valid strobe
//   tx_data, tx_ack    next byte to transmit and its one-cycle latch strobe
//   reg_addr           register bus address
//   reg_wdata, reg_we  write data and one-cycle write strobe
//   reg_re             one-cycle read strobe
//   reg_rdata          read data from the register bus
//   reg_rvalid         one-cycle strobe, reg_rdata valid
//   err_clr            clears the sticky error flag
//   err_o              sticky error flag: read timeout, or a byte received
//                      while a read was still outstanding
//   busy_o             high whenever a frame is in progress (state != CMD)
// ---------------------------------------------------------------------------
module spi_reg_bridge #(
  parameter int          ADDR_W     = 7,
  parameter logic [7:0]  IDLE_BYTE  = 8'hA5,
  parameter int          RD_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ss,
  input  logic [7:0]        rx_data,
  input  logic              rx_ack,
  output logic [7:0]        tx_data,
  output logic              tx_ack,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  input  logic              reg_rvalid,
  input  logic              err_clr,
  output logic              err_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    CMD,
    WR,
    RD_WAIT,
    RD_STREAM
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        ssSync_q, ssSync_d;
  logic              ssDly_q, ssDly_d;
  logic              startPend_q;
  logic [7:0]        txData_q, txData_d;
  logic              txAck_q, txAck_d;
  logic [ADDR_W-1:0] regAddr_q, regAddr_d;
  logic [7:0]        regWdata_q, regWdata_d;
  logic              regWe_q, regWe_d;
  logic              regRe_q, regRe_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              errSet;
  logic              frameEnd;

  // The synchronised slave select is ssSync_q[1]. A frame ends on its 0->1
  // transition, which is detected against a delayed copy of it.
  assign frameEnd = ssSync_q[1] & ~ssDly_q;

  // State and output registers. startPend_q is set by reset. It produces the
  // single tx_ack with IDLE_BYTE on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CMD;
      ssSync_q    <= 2'b11;
      ssDly_q     <= 1'b1;
      startPend_q <= 1'b1;
      txData_q    <= IDLE_BYTE;
      txAck_q     <= 1'b0;
      regAddr_q   <= '0;
      regWdata_q  <= '0;
      regWe_q     <= 1'b0;
      regRe_q     <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ssSync_q    <= ssSync_d;
      ssDly_q     <= ssDly_d;
      startPend_q <= 1'b0;
      txData_q    <= txData_d;
      txAck_q     <= txAck_d;
      regAddr_q   <= regAddr_d;
      regWdata_q  <= regWdata_d;
      regWe_q     <= regWe_d;
      regRe_q     <= regRe_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  // Next-state and strobe logic. All strobes are computed here and registered
  // above, so each one appears one cycle after its triggering event.
  always_comb begin
    state_d    = state_q;
    ssSync_d   = {ssSync_q[0], ss};
    ssDly_d    = ssSync_q[1];
    txData_d   = txData_q;
    txAck_d    = 1'b0;
    regAddr_d  = regAddr_q;
    regWdata_d = regWdata_q;
    regWe_d    = 1'b0;
    regRe_d    = 1'b0;
    cnt_d      = cnt_q;
    errSet     = 1'b0;

    if (startPend_q) begin
      txData_d = IDLE_BYTE;
      txAck_d  = 1'b1;
    end

    // The write address advances on the cycle after the write strobe, so
    // reg_addr is stable while reg_we is high.
    if (regWe_q) begin
      regAddr_d = regAddr_q + ADDR_W'(1);
    end

    if (frameEnd) begin
      // A frame end discards any coincident byte and drops an outstanding read.
      state_d  = CMD;
      txData_d = IDLE_BYTE;
      txAck_d  = 1'b1;
    end else begin
      case (state_q)
        CMD: begin
          if (rx_ack) begin
            regAddr_d = rx_data[ADDR_W-1:0];
            if (rx_data[7]) begin
              state_d  = WR;
              txData_d = IDLE_BYTE;
              txAck_d  = 1'b1;
            end else begin
              state_d = RD_WAIT;
              regRe_d = 1'b1;
              cnt_d   = '0;
            end
          end
        end

        WR: begin
          if (rx_ack) begin
            regWdata_d = rx_data;
            regWe_d    = 1'b1;
          end
        end

        RD_WAIT: begin
          cnt_d = cnt_q + 8'd1;
          if (reg_rvalid) begin
            state_d   = RD_STREAM;
            txData_d  = reg_rdata;
            txAck_d   = 1'b1;
            regAddr_d = regAddr_q + ADDR_W'(1);
          end else if (cnt_q == 8'(RD_TIMEOUT)) begin
            // The bus never answered. Send 0xFF in place of data so the
            // master keeps its byte alignment, and flag the error.
            state_d   = RD_STREAM;
            txData_d  = 8'hFF;
            txAck_d   = 1'b1;
            regAddr_d = regAddr_q + ADDR_W'(1);
            errSet    = 1'b1;
          end
          // A byte that arrives before the read data means the master shifted
          // faster than the bus responded. The byte is dropped.
          if (rx_ack) begin
            errSet = 1'b1;
          end
        end

        RD_STREAM: begin
          if (rx_ack) begin
            state_d = RD_WAIT;
            regRe_d = 1'b1;
            cnt_d   = '0;
          end
        end

        default: begin
          state_d = CMD;
        end
      endcase
    end

    // Clear wins over a coincident set.
    if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q | errSet;
    end
  end

  assign tx_data   = txData_q;
  assign tx_ack    = txAck_q;
  assign reg_addr  = regAddr_q;
  assign reg_wdata = regWdata_q;
  assign reg_we    = regWe_q;
  assign reg_re    = regRe_q;
  assign err_o     = err_q;
  assign busy_o    = (state_q != CMD);

endmodule
